// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : programmable prescaler with cascaded BCD decade tick stages
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int CNT_W   = 19,
  parameter int DEF_DIV = 500000,
  parameter int NUM_STG = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 div_ld,
  input  logic [CNT_W-1:0]     div_val,
  output logic [NUM_STG-1:0]   tick,
  output logic [4*NUM_STG-1:0] digit,
  output logic                 wrap
);

  localparam logic [CNT_W-1:0] c_def_div = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [3:0]       c_nine    = 4'd9;

  logic [CNT_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_dig [NUM_STG];
  logic [NUM_STG-1:0] r_tick;
  logic               r_wrap;

  logic               w_load_ok;
  logic               w_term;
  logic               w_pre_wrap;
  logic [NUM_STG-1:0] w_inc;
  logic               w_chain;
  logic               w_top_wrap;

  assign w_load_ok = div_ld && (div_val != '0);
  assign w_term    = (r_cnt == (r_div - c_one));
  // Terminal count only counts as a wrap when nothing of higher priority owns the edge.
  assign w_pre_wrap = en && !clr && !div_ld && w_term;

  // Carry ripples through the decades within one cycle so all ticks coincide.
  always_comb begin
    w_inc   = '0;
    w_chain = w_pre_wrap;
    for (int i = 0; i < NUM_STG; i++) begin
      w_inc[i] = w_chain;
      w_chain  = w_chain && (r_dig[i] == c_nine);
    end
    w_top_wrap = w_chain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= c_def_div;
    end else if (w_load_ok) begin
      r_div <= div_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || div_ld) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_term ? '0 : (r_cnt + c_one);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STG; i++) begin
        r_dig[i] <= 4'd0;
      end
    end else if (clr) begin
      for (int i = 0; i < NUM_STG; i++) begin
        r_dig[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_STG; i++) begin
        if (w_inc[i]) begin
          r_dig[i] <= (r_dig[i] == c_nine) ? 4'd0 : (r_dig[i] + 4'd1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_inc;
      r_wrap <= w_top_wrap;
    end
  end

  generate
    for (genvar g = 0; g < NUM_STG; g++) begin : g_digit
      assign digit[4*g +: 4] = r_dig[g];
    end
  endgenerate

  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_tick_gen.sv
// ============================================================================
// tb_tick_gen : directed self-checking bench for tick_gen (DEF_DIV=5, 3 stages)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tick_gen;

  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 5;
  localparam int NUM_STG = 3;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             en      = 1'b0;
  logic             clr     = 1'b0;
  logic             div_ld  = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic [NUM_STG-1:0]   tick;
  logic [4*NUM_STG-1:0] digit;
  logic                 wrap;

  int n_checks = 0;
  int n_pass   = 0;

  tick_gen #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .NUM_STG (NUM_STG)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .div_ld  (div_ld),
    .div_val (div_val),
    .tick    (tick),
    .digit   (digit),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    // Reset state
    steps(2);
    check("rst_tick",  32'(tick),  32'h0);
    check("rst_digit", 32'(digit), 32'h0);
    check("rst_wrap",  32'(wrap),  32'h0);

    // Base rate: ticks after edges 5, 10, 15
    rst_n = 1'b1;
    en    = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      check("base_tick0",  32'(tick[0]),     (e % 5 == 0) ? 32'h1 : 32'h0);
      check("base_digit0", 32'(digit[3:0]),  32'(e / 5));
    end
    check("base_tick1", 32'(tick[1]), 32'h0);

    // Asynchronous reset mid-count with digit0 = 3
    steps(2);
    check("pre_rst_digit0", 32'(digit[3:0]), 32'h3);
    #1 rst_n = 1'b0;
    #2;
    check("async_rst_digit", 32'(digit), 32'h0);
    check("async_rst_tick",  32'(tick),  32'h0);
    check("async_rst_wrap",  32'(wrap),  32'h0);
    rst_n = 1'b1;

    // First tick exactly 5 enabled edges after release (div_r back to 5)
    for (int e = 1; e <= 5; e++) begin
      step();
      check("post_rst_tick0", 32'(tick[0]), (e == 5) ? 32'h1 : 32'h0);
    end

    // Cascade: 10th tick0 at edge 50
    steps(44);
    check("casc49_tick", 32'(tick), 32'h0);
    step();
    check("casc50_tick",  32'(tick),  32'h3);
    check("casc50_digit", 32'(digit), 32'h010);
    steps(4944);
    step();
    check("casc4995_digit", 32'(digit), 32'h999);
    check("casc4995_tick",  32'(tick),  32'h1);
    check("casc4995_wrap",  32'(wrap),  32'h0);
    steps(4);
    step();
    check("casc5000_tick",  32'(tick),  32'h7);
    check("casc5000_wrap",  32'(wrap),  32'h1);
    check("casc5000_digit", 32'(digit), 32'h000);
    step();
    check("casc5001_tick", 32'(tick), 32'h0);
    check("casc5001_wrap", 32'(wrap), 32'h0);

    // Enable: pause 3 cycles at cnt = 2
    steps(3);
    step();
    check("en_pre_tick0",  32'(tick[0]),    32'h1);
    check("en_pre_digit0", 32'(digit[3:0]), 32'h1);
    steps(2);
    en = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      check("en_low_tick",   32'(tick),       32'h0);
      check("en_low_digit0", 32'(digit[3:0]), 32'h1);
    end
    en = 1'b1;
    steps(2);
    check("en_resume_early", 32'(tick[0]), 32'h0);
    step();
    check("en_resume_tick0",  32'(tick[0]),    32'h1);
    check("en_resume_digit0", 32'(digit[3:0]), 32'h2);

    // Load divisor 3 at terminal count
    steps(4);
    div_ld  = 1'b1;
    div_val = 8'd3;
    step();
    div_ld  = 1'b0;
    check("ld_tick",   32'(tick),       32'h0);
    check("ld_digit0", 32'(digit[3:0]), 32'h2);
    steps(2);
    check("ld3_early", 32'(tick[0]), 32'h0);
    step();
    check("ld3_tick0",  32'(tick[0]),    32'h1);
    check("ld3_digit0", 32'(digit[3:0]), 32'h3);
    steps(2);
    check("ld3_p2_early", 32'(tick[0]), 32'h0);
    step();
    check("ld3_p2_tick0",  32'(tick[0]),    32'h1);
    check("ld3_p2_digit0", 32'(digit[3:0]), 32'h4);

    // Zero divisor load is ignored but still zeroes the counter
    step();
    div_ld  = 1'b1;
    div_val = 8'd0;
    step();
    div_ld  = 1'b0;
    check("ld0_tick", 32'(tick), 32'h0);
    steps(2);
    check("ld0_early", 32'(tick[0]), 32'h0);
    step();
    check("ld0_tick0",  32'(tick[0]),    32'h1);
    check("ld0_digit0", 32'(digit[3:0]), 32'h5);
    steps(2);
    step();
    check("ld0_p2_tick0",  32'(tick[0]),    32'h1);
    check("ld0_p2_digit0", 32'(digit[3:0]), 32'h6);

    // Clear colliding with terminal count and a pending carry
    div_ld  = 1'b1;
    div_val = 8'd5;
    step();
    div_ld  = 1'b0;
    steps(15);
    check("clr_pre_digit", 32'(digit), 32'h009);
    steps(4);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_tick",  32'(tick),  32'h0);
    check("clr_digit", 32'(digit), 32'h000);
    check("clr_wrap",  32'(wrap),  32'h0);
    steps(4);
    check("clr_after_early", 32'(tick[0]), 32'h0);
    step();
    check("clr_after_tick",  32'(tick),  32'h1);
    check("clr_after_digit", 32'(digit), 32'h001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
